// File: rtl/ulpb_lc_handshake.sv
// -----------------------------------------------------------------------------
// ulpb_lc_handshake
//
// Layer-controller endpoint of the ULPB bus-controller / layer-controller link.
// The block lives in the power-gated layer domain, behind the isolation cells.
// It turns two simple user-side ports into the 4-phase handshakes that the bus
// controller (BC) expects:
//   - TX: a user start/done port becomes TX_REQ/TX_ACK followed by
//     TX_SUCC|TX_FAIL / TX_RESP_ACK.
//   - RX: RX_REQ/RX_ACK becomes a one-entry valid/ready buffer.
// The TX and RX engines are independent and may be active at the same time.
//
// Ports
//   CLK, RESETn                 layer clock, synchronous active-low reset
//   USR_TX_START/ADDR/DATA/
//     PEND/PRIO                 user TX request, captured on an accepted start
//   USR_TX_BUSY/DONE/OK         user TX status (OK is valid with DONE)
//   USR_RX_VALID/READY          user RX buffer handshake
//   USR_RX_ADDR/DATA/PEND       buffered RX word
//   USR_RX_ERR                  one-cycle pulse on a rising edge of RX_FAIL
//   TX_ADDR/DATA/PEND/REQ,
//     PRIORITY, TX_RESP_ACK     registered outputs to the BC
//   TX_ACK/SUCC/FAIL            TX handshake inputs from the BC
//   RX_ADDR/DATA/PEND/REQ/FAIL  RX inputs from the BC
//   RX_ACK                      registered RX acknowledge to the BC
// -----------------------------------------------------------------------------
module ulpb_lc_handshake #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    // user TX port
    input  logic                  USR_TX_START,
    input  logic [ADDR_WIDTH-1:0] USR_TX_ADDR,
    input  logic [DATA_WIDTH-1:0] USR_TX_DATA,
    input  logic                  USR_TX_PEND,
    input  logic                  USR_TX_PRIO,
    output logic                  USR_TX_BUSY,
    output logic                  USR_TX_DONE,
    output logic                  USR_TX_OK,
    // user RX port
    output logic                  USR_RX_VALID,
    input  logic                  USR_RX_READY,
    output logic [ADDR_WIDTH-1:0] USR_RX_ADDR,
    output logic [DATA_WIDTH-1:0] USR_RX_DATA,
    output logic                  USR_RX_PEND,
    output logic                  USR_RX_ERR,
    // BC TX side
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_PEND,
    output logic                  TX_REQ,
    output logic                  PRIORITY,
    input  logic                  TX_ACK,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK,
    // BC RX side
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_PEND,
    input  logic                  RX_REQ,
    input  logic                  RX_FAIL,
    output logic                  RX_ACK
);

    typedef enum logic [2:0] {
        TXS_IDLE,
        TXS_REQ,
        TXS_ACKLO,
        TXS_RESP,
        TXS_RESPLO
    } tx_state_t;

    typedef enum logic [0:0] {
        RXS_IDLE,
        RXS_ACK
    } rx_state_t;

    // ---------------- TX engine ----------------
    tx_state_t             tx_state_reg, tx_state_next;
    logic [ADDR_WIDTH-1:0] tx_addr_reg,  tx_addr_next;
    logic [DATA_WIDTH-1:0] tx_data_reg,  tx_data_next;
    logic                  tx_pend_reg,  tx_pend_next;
    logic                  tx_prio_reg,  tx_prio_next;
    logic                  tx_req_reg,   tx_req_next;
    logic                  resp_ack_reg, resp_ack_next;
    logic                  busy_reg,     busy_next;
    logic                  done_reg,     done_next;
    logic                  ok_reg,       ok_next;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_addr_next  = tx_addr_reg;
        tx_data_next  = tx_data_reg;
        tx_pend_next  = tx_pend_reg;
        tx_prio_next  = tx_prio_reg;
        tx_req_next   = tx_req_reg;
        resp_ack_next = resp_ack_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        ok_next       = ok_reg;
        case (tx_state_reg)
            TXS_IDLE: begin
                // BUSY is low only in IDLE, so a start anywhere else is ignored.
                if (USR_TX_START) begin
                    tx_addr_next  = USR_TX_ADDR;
                    tx_data_next  = USR_TX_DATA;
                    tx_pend_next  = USR_TX_PEND;
                    tx_prio_next  = USR_TX_PRIO;
                    tx_req_next   = 1'b1;
                    busy_next     = 1'b1;
                    tx_state_next = TXS_REQ;
                end
            end
            TXS_REQ: begin
                if (TX_ACK) begin
                    tx_req_next   = 1'b0;
                    tx_state_next = TXS_ACKLO;
                end
            end
            TXS_ACKLO: begin
                if (!TX_ACK) begin
                    tx_state_next = TXS_RESP;
                end
            end
            TXS_RESP: begin
                // SUCC/FAIL are levels held by the BC, so a response raised
                // early (during REQ/ACKLO) is simply picked up here.
                if (TX_SUCC || TX_FAIL) begin
                    resp_ack_next = 1'b1;
                    ok_next       = TX_SUCC & ~TX_FAIL;
                    tx_state_next = TXS_RESPLO;
                end
            end
            TXS_RESPLO: begin
                if (!TX_SUCC && !TX_FAIL) begin
                    resp_ack_next = 1'b0;
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    tx_addr_next  = '0;
                    tx_data_next  = '0;
                    tx_pend_next  = 1'b0;
                    tx_prio_next  = 1'b0;
                    tx_state_next = TXS_IDLE;
                end
            end
            default: tx_state_next = TXS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            tx_state_reg <= TXS_IDLE;
            tx_addr_reg  <= '0;
            tx_data_reg  <= '0;
            tx_pend_reg  <= 1'b0;
            tx_prio_reg  <= 1'b0;
            tx_req_reg   <= 1'b0;
            resp_ack_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ok_reg       <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_addr_reg  <= tx_addr_next;
            tx_data_reg  <= tx_data_next;
            tx_pend_reg  <= tx_pend_next;
            tx_prio_reg  <= tx_prio_next;
            tx_req_reg   <= tx_req_next;
            resp_ack_reg <= resp_ack_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            ok_reg       <= ok_next;
        end
    end

    // ---------------- RX engine ----------------
    rx_state_t             rx_state_reg, rx_state_next;
    logic [ADDR_WIDTH-1:0] rx_addr_reg,  rx_addr_next;
    logic [DATA_WIDTH-1:0] rx_data_reg,  rx_data_next;
    logic                  rx_pend_reg,  rx_pend_next;
    logic                  valid_reg,    valid_next;
    logic                  rx_ack_reg,   rx_ack_next;
    logic                  fail_d_reg,   fail_d_next;
    logic                  err_reg,      err_next;
    logic                  pop;

    assign pop = valid_reg & USR_RX_READY;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_addr_next  = rx_addr_reg;
        rx_data_next  = rx_data_reg;
        rx_pend_next  = rx_pend_reg;
        valid_next    = valid_reg;
        rx_ack_next   = rx_ack_reg;
        fail_d_next   = RX_FAIL;
        err_next      = RX_FAIL & ~fail_d_reg;
        if (pop) begin
            valid_next = 1'b0;
        end
        case (rx_state_reg)
            RXS_IDLE: begin
                // A pop in the same cycle frees the slot; the capture then
                // overrides the clear above so VALID stays high.
                if (RX_REQ && (!valid_reg || pop)) begin
                    rx_addr_next  = RX_ADDR;
                    rx_data_next  = RX_DATA;
                    rx_pend_next  = RX_PEND;
                    valid_next    = 1'b1;
                    rx_ack_next   = 1'b1;
                    rx_state_next = RXS_ACK;
                end
            end
            RXS_ACK: begin
                if (!RX_REQ) begin
                    rx_ack_next   = 1'b0;
                    rx_state_next = RXS_IDLE;
                end
            end
            default: rx_state_next = RXS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rx_state_reg <= RXS_IDLE;
            rx_addr_reg  <= '0;
            rx_data_reg  <= '0;
            rx_pend_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            rx_ack_reg   <= 1'b0;
            fail_d_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_addr_reg  <= rx_addr_next;
            rx_data_reg  <= rx_data_next;
            rx_pend_reg  <= rx_pend_next;
            valid_reg    <= valid_next;
            rx_ack_reg   <= rx_ack_next;
            fail_d_reg   <= fail_d_next;
            err_reg      <= err_next;
        end
    end

    // ---------------- outputs ----------------
    assign USR_TX_BUSY  = busy_reg;
    assign USR_TX_DONE  = done_reg;
    assign USR_TX_OK    = ok_reg;
    assign TX_ADDR      = tx_addr_reg;
    assign TX_DATA      = tx_data_reg;
    assign TX_PEND      = tx_pend_reg;
    assign PRIORITY     = tx_prio_reg;
    assign TX_REQ       = tx_req_reg;
    assign TX_RESP_ACK  = resp_ack_reg;
    assign USR_RX_VALID = valid_reg;
    assign USR_RX_ADDR  = rx_addr_reg;
    assign USR_RX_DATA  = rx_data_reg;
    assign USR_RX_PEND  = rx_pend_reg;
    assign USR_RX_ERR   = err_reg;
    assign RX_ACK       = rx_ack_reg;

endmodule

// File: tb/tb_ulpb_lc_handshake.sv
// -----------------------------------------------------------------------------
// tb_ulpb_lc_handshake
//
// Self-checking bench for ulpb_lc_handshake. A behavioural BC drives the
// TX/RX handshakes; expected TX outcomes and RX words are queued when the
// stimulus is issued and compared when the DUT produces DONE or a pop.
// -----------------------------------------------------------------------------
module tb_ulpb_lc_handshake;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          USR_TX_START;
    logic [AW-1:0] USR_TX_ADDR;
    logic [DW-1:0] USR_TX_DATA;
    logic          USR_TX_PEND, USR_TX_PRIO;
    logic          USR_TX_BUSY, USR_TX_DONE, USR_TX_OK;
    logic          USR_RX_VALID, USR_RX_READY;
    logic [AW-1:0] USR_RX_ADDR;
    logic [DW-1:0] USR_RX_DATA;
    logic          USR_RX_PEND, USR_RX_ERR;
    logic [AW-1:0] TX_ADDR;
    logic [DW-1:0] TX_DATA;
    logic          TX_PEND, TX_REQ, PRIORITY;
    logic          TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;
    logic [AW-1:0] RX_ADDR;
    logic [DW-1:0] RX_DATA;
    logic          RX_PEND, RX_REQ, RX_FAIL, RX_ACK;

    ulpb_lc_handshake #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .USR_TX_START(USR_TX_START), .USR_TX_ADDR(USR_TX_ADDR),
        .USR_TX_DATA(USR_TX_DATA), .USR_TX_PEND(USR_TX_PEND),
        .USR_TX_PRIO(USR_TX_PRIO), .USR_TX_BUSY(USR_TX_BUSY),
        .USR_TX_DONE(USR_TX_DONE), .USR_TX_OK(USR_TX_OK),
        .USR_RX_VALID(USR_RX_VALID), .USR_RX_READY(USR_RX_READY),
        .USR_RX_ADDR(USR_RX_ADDR), .USR_RX_DATA(USR_RX_DATA),
        .USR_RX_PEND(USR_RX_PEND), .USR_RX_ERR(USR_RX_ERR),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND),
        .TX_REQ(TX_REQ), .PRIORITY(PRIORITY), .TX_ACK(TX_ACK),
        .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL), .TX_RESP_ACK(TX_RESP_ACK),
        .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_PEND(RX_PEND),
        .RX_REQ(RX_REQ), .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK)
    );

    always #5 CLK = ~CLK;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    bit               tx_q[$];
    logic [AW+DW:0]   rx_q[$];   // {pend, addr, data}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic probe(input int idx);
        case (idx)
            0:       return TX_REQ;
            1:       return TX_RESP_ACK;
            2:       return USR_TX_DONE;
            3:       return RX_ACK;
            default: return USR_RX_VALID;
        endcase
    endfunction

    // Bounded wait; an expired budget shows up as a failed comparison.
    task automatic wait_for(input int idx, input logic lvl, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (probe(idx) == lvl) break;
            tick();
        end
        check(tag, probe(idx), lvl);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {TX_REQ, TX_RESP_ACK, RX_ACK, USR_TX_BUSY, USR_TX_DONE,
                              USR_TX_OK, USR_RX_VALID, USR_RX_ERR, TX_PEND, PRIORITY,
                              USR_RX_PEND}, 0);
        check({tag, "_txbus"}, {TX_ADDR, TX_DATA}, 0);
        check({tag, "_rxbuf"}, {USR_RX_ADDR, USR_RX_DATA}, 0);
    endtask

    // Scoreboard side: compare at the falling edge, away from the DUT's edge.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (USR_TX_DONE) begin
                done_cnt++;
                if (tx_q.size() == 0) check("tx_sb_underflow", 1, 0);
                else begin
                    automatic bit e = tx_q.pop_front();
                    $display("tx done ok=%0b", USR_TX_OK);
                    check("tx_ok", USR_TX_OK, e);
                end
            end
            if (USR_RX_VALID && USR_RX_READY) begin
                if (rx_q.size() == 0) check("rx_sb_underflow", 1, 0);
                else begin
                    automatic logic [AW+DW:0] e = rx_q.pop_front();
                    $display("rx pop addr=%0h data=%0h pend=%0b", USR_RX_ADDR, USR_RX_DATA, USR_RX_PEND);
                    check("rx_word", {USR_RX_PEND, USR_RX_ADDR, USR_RX_DATA}, e);
                end
            end
            if (USR_RX_ERR) err_cnt++;
        end
    end

    // One full TX transaction with a behavioural BC.
    task automatic tx_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit pend,
                          input bit prio, input int ack_dly, input bit succ, input bit fail,
                          input bit early_resp, input bit poke_start);
        tx_q.push_back(succ & ~fail);
        USR_TX_ADDR = a; USR_TX_DATA = d; USR_TX_PEND = pend; USR_TX_PRIO = prio;
        USR_TX_START = 1'b1;
        tick();
        USR_TX_START = 1'b0;
        wait_for(0, 1'b1, "tx_req_rise");
        check("tx_busy", USR_TX_BUSY, 1);
        check("tx_bus", {PRIORITY, TX_PEND, TX_ADDR, TX_DATA}, {prio, pend, a, d});
        if (poke_start) begin
            USR_TX_ADDR = ~a; USR_TX_DATA = ~d; USR_TX_START = 1'b1;
            tick();
            USR_TX_START = 1'b0;
            check("tx_start_ignored", {TX_ADDR, TX_DATA}, {a, d});
        end
        repeat (ack_dly) tick();
        TX_ACK = 1'b1;
        if (early_resp) begin TX_SUCC = succ; TX_FAIL = fail; end
        wait_for(0, 1'b0, "tx_req_fall");
        TX_ACK = 1'b0;
        check("tx_data_stable", TX_DATA, d);
        TX_SUCC = succ; TX_FAIL = fail;
        wait_for(1, 1'b1, "tx_resp_ack_rise");
        check("tx_addr_stable", TX_ADDR, a);
        check("tx_no_early_done", USR_TX_DONE, 0);
        TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        wait_for(2, 1'b1, "tx_done");
        check("tx_end_state", {TX_RESP_ACK, USR_TX_BUSY, TX_ADDR, TX_DATA}, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        automatic int d0;
        RESETn = 1'b0;
        USR_TX_START = 0; USR_TX_ADDR = 0; USR_TX_DATA = 0; USR_TX_PEND = 0; USR_TX_PRIO = 0;
        USR_RX_READY = 0;
        TX_ACK = 0; TX_SUCC = 0; TX_FAIL = 0;
        RX_ADDR = 0; RX_DATA = 0; RX_PEND = 0; RX_REQ = 0; RX_FAIL = 0;
        repeat (3) tick();
        check_all_zero("reset");
        RESETn = 1'b1;
        tick();

        // 1: plain successful TX, BC acks after 2 cycles
        tx_txn(8'hA5, 32'hDEADBEEF, 1, 0, 2, 1, 0, 0, 0);

        // 2: SUCC and FAIL together -> FAIL; start during BUSY is ignored
        d0 = done_cnt;
        tx_txn(8'h5A, 32'h0BADF00D, 0, 1, 1, 1, 1, 0, 1);
        repeat (3) tick();
        check("tx_single_done", done_cnt - d0, 1);

        // 3: RX word with consumer ready
        USR_RX_READY = 1'b1;
        RX_ADDR = 8'h11; RX_DATA = 32'h12345678; RX_PEND = 1'b1; RX_REQ = 1'b1;
        rx_q.push_back({1'b1, 8'h11, 32'h12345678});
        tick();
        check("rx_valid_ack", {USR_RX_VALID, RX_ACK}, 2'b11);
        RX_REQ = 1'b0;
        tick();
        check("rx_ack_drop_pop", {USR_RX_VALID, RX_ACK}, 2'b00);
        USR_RX_READY = 1'b0;

        // 4: backpressure, then pop and capture in the same cycle
        RX_ADDR = 8'h21; RX_DATA = 32'hAAAA0001; RX_PEND = 1'b0; RX_REQ = 1'b1;
        rx_q.push_back({1'b0, 8'h21, 32'hAAAA0001});
        wait_for(3, 1'b1, "rx_a_ack_rise");
        RX_REQ = 1'b0;
        wait_for(3, 1'b0, "rx_a_ack_fall");
        RX_ADDR = 8'h22; RX_DATA = 32'hBBBB0002; RX_PEND = 1'b1; RX_REQ = 1'b1;
        rx_q.push_back({1'b1, 8'h22, 32'hBBBB0002});
        repeat (3) tick();
        check("rx_backpressure", {RX_ACK, USR_RX_VALID}, 2'b01);
        check("rx_no_overwrite", USR_RX_DATA, 32'hAAAA0001);
        USR_RX_READY = 1'b1;
        tick();
        USR_RX_READY = 1'b0;
        check("rx_pop_capture", {USR_RX_VALID, RX_ACK, USR_RX_DATA}, {2'b11, 32'hBBBB0002});
        RX_REQ = 1'b0;
        wait_for(3, 1'b0, "rx_b_ack_fall");
        USR_RX_READY = 1'b1;
        tick();
        USR_RX_READY = 1'b0;
        check("rx_drained", USR_RX_VALID, 0);

        // 5: reset mid-response and mid-RX ack
        d0 = done_cnt;
        USR_TX_ADDR = 8'h77; USR_TX_DATA = 32'h77777777; USR_TX_START = 1'b1;
        tick();
        USR_TX_START = 1'b0;
        TX_ACK = 1'b1;
        wait_for(0, 1'b0, "rst_tx_req_fall");
        TX_ACK = 1'b0;
        TX_SUCC = 1'b1;
        RX_ADDR = 8'h33; RX_DATA = 32'h33333333; RX_REQ = 1'b1;
        wait_for(1, 1'b1, "rst_resp_ack");
        check("rst_rx_ack", RX_ACK, 1);
        RESETn = 1'b0;
        TX_SUCC = 1'b0; RX_REQ = 1'b0;
        tick();
        check_all_zero("midreset");
        RESETn = 1'b1;
        repeat (3) tick();
        check("rst_no_done", done_cnt - d0, 0);
        tx_txn(8'hC3, 32'h0F0F0F0F, 1, 1, 0, 1, 0, 0, 0);

        // 6: RX_FAIL pulse while TX is active; response raised early
        d0 = err_cnt;
        fork
            tx_txn(8'h3C, 32'hCAFEF00D, 0, 1, 3, 1, 0, 1, 0);
            begin
                repeat (2) tick();
                RX_FAIL = 1'b1;
                repeat (3) tick();
                RX_FAIL = 1'b0;
            end
        join
        repeat (2) tick();
        check("rx_err_pulses", err_cnt - d0, 1);
        check("rx_err_no_valid", USR_RX_VALID, 0);

        check("tx_sb_left", tx_q.size(), 0);
        check("rx_sb_left", rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
